// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl: PS/2 keyboard front end that turns raw PS/2 clk/data into game key events.
//   Synchronises the PS/2 lines, deframes bytes (parity/stop/timeout checked), decodes
//   E0/F0 prefixed scan codes, tracks held game keys and queues events in a FWFT FIFO.
// Ports:
//   i_clk, i_rst_n            system clock, asynchronous active-low reset
//   i_ps2_clk, i_ps2_data     raw PS/2 lines (asynchronous)
//   o_evt, o_evt_valid        FIFO head {brk, ext, code[7:0]} and non-empty flag
//   i_evt_ready               consumer pops the head when valid & ready
//   o_key_held                held flags {space,enter,left,right,down,up}
//   o_overflow, o_frame_err   sticky error flags, cleared by the i_clr_err pulse
module ps2_key_event_ctrl #(
    parameter int TIMEOUT_CYC = 5000,
    parameter int FIFO_DEPTH  = 4,
    parameter int FILTER_RPT  = 1,
    parameter int ONLY_MAPPED = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [9:0] o_evt,
    output logic       o_evt_valid,
    input  logic       i_evt_ready,
    output logic [5:0] o_key_held,
    output logic       o_overflow,
    output logic       o_frame_err,
    input  logic       i_clr_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {F_IDLE, F_DATA, F_PAR, F_STOP} frame_t;
    typedef enum logic [1:0] {S_BASE, S_EXT, S_BRK, S_EXT_BRK} scan_t;

    logic [2:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          fall;
    logic          ps2_dat;
    frame_t        frame_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] wd_q;
    logic          byte_vld_q;
    logic          ferr_q;
    scan_t         scan_q;
    logic          cmp_vld_q;
    logic [9:0]    cmp_q;
    logic [5:0]    key_oh;
    logic          mapped;
    logic          rpt;
    logic          push;
    logic [5:0]    held_q;
    logic [5:0]    held_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_q;
    logic [AW:0]   rd_q;
    logic          empty;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          ovf_q;
    logic          ovf_d;
    logic          err_q;
    logic          err_d;

    // Bit [1] is the synchronised clock, bit [2] its one-cycle-delayed copy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], i_ps2_clk};
            dat_sync_q <= {dat_sync_q[0], i_ps2_data};
        end
    end

    assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
    assign ps2_dat = dat_sync_q[1];

    // Frame FSM; the watchdog restarts on every fall and only runs mid-frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_q    <= F_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            wd_q       <= '0;
            byte_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            byte_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
            wd_q       <= (frame_q == F_IDLE || fall) ? '0 : wd_q + 1'b1;
            if (frame_q != F_IDLE && !fall && wd_q == TW'(TIMEOUT_CYC - 1)) begin
                frame_q <= F_IDLE;
                ferr_q  <= 1'b1;
            end else if (fall) begin
                case (frame_q)
                    F_IDLE: begin
                        if (!ps2_dat) frame_q <= F_DATA;
                        bit_cnt_q <= '0;
                    end
                    F_DATA: begin
                        shift_q   <= {ps2_dat, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) frame_q <= F_PAR;
                    end
                    F_PAR: begin
                        par_q   <= ps2_dat;
                        frame_q <= F_STOP;
                    end
                    default: begin
                        frame_q <= F_IDLE;
                        if (ps2_dat && (^{shift_q, par_q})) byte_vld_q <= 1'b1;
                        else ferr_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Scan FSM; shift_q is stable for many cycles after byte_vld, so it serves as the byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scan_q    <= S_BASE;
            cmp_vld_q <= 1'b0;
            cmp_q     <= '0;
        end else begin
            cmp_vld_q <= 1'b0;
            if (byte_vld_q) begin
                if (shift_q == 8'hE0) begin
                    scan_q <= (scan_q == S_BRK || scan_q == S_EXT_BRK) ? S_EXT_BRK : S_EXT;
                end else if (shift_q == 8'hF0) begin
                    scan_q <= (scan_q == S_EXT || scan_q == S_EXT_BRK) ? S_EXT_BRK : S_BRK;
                end else begin
                    cmp_vld_q <= 1'b1;
                    cmp_q     <= {scan_q == S_BRK || scan_q == S_EXT_BRK,
                                  scan_q == S_EXT || scan_q == S_EXT_BRK, shift_q};
                    scan_q    <= S_BASE;
                end
            end
        end
    end

    // Extended codes alias their base keys, so only the code byte is matched.
    assign key_oh = {cmp_q[7:0] == 8'h29, cmp_q[7:0] == 8'h5A, cmp_q[7:0] == 8'h6B,
                     cmp_q[7:0] == 8'h74, cmp_q[7:0] == 8'h72, cmp_q[7:0] == 8'h75};
    assign mapped = |key_oh;
    assign rpt    = (|(key_oh & held_q)) & ~cmp_q[9];
    assign push   = cmp_vld_q & ((ONLY_MAPPED == 0) | mapped) & ~((FILTER_RPT != 0) & rpt);
    assign held_d = !cmp_vld_q ? held_q : cmp_q[9] ? (held_q & ~key_oh) : (held_q | key_oh);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = wr_q == rd_q;
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = ~empty & i_evt_ready;
    assign wr_en = push & (~full | pop);
    assign ovf_d = (push & full & ~pop) | (ovf_q & ~i_clr_err);
    assign err_d = ferr_q | (err_q & ~i_clr_err);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            held_q <= '0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q[AW-1:0]] <= cmp_q;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            held_q <= held_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
        end
    end

    assign o_evt       = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign o_evt_valid = ~empty;
    assign o_key_held  = held_q;
    assign o_overflow  = ovf_q;
    assign o_frame_err = err_q;
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb_ps2_key_event_ctrl: scoreboard bench driving PS/2 frames into ps2_key_event_ctrl.
module tb_ps2_key_event_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [9:0] evt;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [5:0] key_held;
    logic       overflow;
    logic       frame_err;
    logic       clr_err = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [9:0] exp_q [$];

    ps2_key_event_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_data  (ps2_data),
        .o_evt       (evt),
        .o_evt_valid (evt_valid),
        .i_evt_ready (evt_ready),
        .o_key_held  (key_held),
        .o_overflow  (overflow),
        .o_frame_err (frame_err),
        .i_clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        tick(10);
        ps2_clk = 1'b0;
        tick(20);
        ps2_clk = 1'b1;
        tick(10);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        send_bit(1'b1);
        tick(20);
    endtask

    task automatic pulse_clr;
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        tick(2);
    endtask

    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) check("unexpected_evt", {6'b0, evt}, 16'hFFFF);
            else check("evt", {6'b0, evt}, {6'b0, exp_q.pop_front()});
        end
    end

    initial begin
        tick(5);
        check("rst_valid", {15'b0, evt_valid}, 16'h0);
        check("rst_evt", {6'b0, evt}, 16'h0);
        check("rst_held", {10'b0, key_held}, 16'h0);
        check("rst_ovf", {15'b0, overflow}, 16'h0);
        check("rst_err", {15'b0, frame_err}, 16'h0);
        rst_n = 1'b1;
        tick(5);

        exp_q.push_back(10'h175);
        send_byte(8'hE0, 1'b0); send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
        check("held_up", {10'b0, key_held}, 16'h0001);
        exp_q.push_back(10'h375);
        send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
        check("held_up_rel", {10'b0, key_held}, 16'h0000);

        exp_q.push_back(10'h029);
        send_byte(8'h29, 1'b0); send_byte(8'h29, 1'b0);
        check("held_space", {10'b0, key_held}, 16'h0020);
        check("rpt_drained", exp_q.size(), 16'h0);
        exp_q.push_back(10'h229);
        send_byte(8'hF0, 1'b0); send_byte(8'h29, 1'b0);
        check("held_space_rel", {10'b0, key_held}, 16'h0000);

        send_byte(8'h5A, 1'b1);
        check("par_err", {15'b0, frame_err}, 16'h1);
        check("par_no_evt", {15'b0, evt_valid}, 16'h0);
        check("par_held", {10'b0, key_held}, 16'h0000);
        pulse_clr;
        check("par_clr", {15'b0, frame_err}, 16'h0);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        tick(6000);
        check("timeout_err", {15'b0, frame_err}, 16'h1);
        pulse_clr;
        exp_q.push_back(10'h072);
        send_byte(8'h72, 1'b0);
        check("after_to_held", {10'b0, key_held}, 16'h0002);
        exp_q.push_back(10'h272);
        send_byte(8'hF0, 1'b0); send_byte(8'h72, 1'b0);
        check("after_to_rel", {10'b0, key_held}, 16'h0000);

        evt_ready = 1'b0;
        exp_q.push_back(10'h075); exp_q.push_back(10'h072);
        exp_q.push_back(10'h074); exp_q.push_back(10'h06B);
        send_byte(8'h75, 1'b0); send_byte(8'h72, 1'b0); send_byte(8'h74, 1'b0);
        send_byte(8'h6B, 1'b0); send_byte(8'h5A, 1'b0);
        check("ovf_set", {15'b0, overflow}, 16'h1);
        check("ovf_valid", {15'b0, evt_valid}, 16'h1);
        check("ovf_head", {6'b0, evt}, 16'h0075);
        check("ovf_held", {10'b0, key_held}, 16'h001F);
        evt_ready = 1'b1;
        tick(10);
        check("drain_empty", exp_q.size(), 16'h0);
        check("drain_valid", {15'b0, evt_valid}, 16'h0);
        pulse_clr;
        check("ovf_clr", {15'b0, overflow}, 16'h0);

        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        #3 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        check("mid_rst_held", {10'b0, key_held}, 16'h0000);
        check("mid_rst_valid", {15'b0, evt_valid}, 16'h0);
        check("mid_rst_err", {15'b0, frame_err}, 16'h0);
        exp_q.push_back(10'h029);
        send_byte(8'h29, 1'b0);
        check("post_rst_held", {10'b0, key_held}, 16'h0020);
        tick(10);
        check("final_empty", exp_q.size(), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
